ram_banked_ctrl: RTL
====================

// Module: ram_banked_ctrl
// PURPOSE
//  Parametrised successor to the fixed 1Kx64 RAM. Tiles 32-bit x 1024-word DFFRAM macros into a DATA_W x DEPTH memory.
//  Adds a valid/ready request port, a registered read-response channel with backpressure, and byte-masked writes.
//  A reset-time clear FSM zeroes all contents before the first request is accepted.
//  Sits between the core's data/instruction bus adapters and the macro array.
// PARAMETERS
//  DATA_W    64    word width; multiple of 32. COLS = DATA_W/32 macros per row.
//  DEPTH     2048  words; multiple of 1024. ROWS = DEPTH/1024 macro rows.
//  CLEAR_EN  1     1: run the clear FSM after reset. 0: ready immediately after reset; contents undefined.
//  USE_BEH   0     1: instantiate DFFRAM_beh. 0: instantiate DFFRAM_4K.
// PORTS
//  CLK        in   1                 single clock; all logic is rising-edge.
//  RESETn     in   1                 asynchronous, active-low reset.
//  req_valid  in   1                 request present.
//  req_ready  out  1                 request accepted when req_valid & req_ready.
//  req_we     in   DATA_W/8          byte write mask; 0 = read, nonzero = write.
//  req_addr   in   $clog2(DEPTH)     word address.
//  req_wdata  in   DATA_W            write data.
//  rsp_valid  out  1                 read data valid.
//  rsp_ready  in   1                 consumer accepts rsp_rdata.
//  rsp_rdata  out  DATA_W            read data; held stable while rsp_valid & !rsp_ready.
//  init_done  out  1                 clear complete; stays 1 until the next reset.
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0. FSM goes to CLEAR, or RUN if CLEAR_EN=0.
//  FSM CLEAR:
//   - Counter clr_addr runs 0..1023.
//   - All rows and columns are enabled with WE all ones and Di=0, so every row clears in parallel.
//   - After writing address 1023, FSM goes to RUN and init_done rises in the same cycle. Duration is 1024 cycles.
//   - req_ready=0 throughout CLEAR.
//  FSM RUN: req_ready = !rsp_valid | rsp_ready.
//  Address split: row = req_addr[AW-1:10], macro addr = req_addr[9:0].
//   - Only the selected row gets EN=1. Column c gets WE = req_we[4c+3:4c].
//  Write accept: bytes written at the next edge. No response is produced. rsp_valid is unaffected.
//  Read accept:
//   - The row index is registered.
//   - rsp_valid=1 in the following cycle (latency 1), with rsp_rdata = Do of the registered row.
//   - Macro Do is captured into the rsp_rdata hold register in that cycle. rsp_rdata must not depend on later macro activity.
//  Stall: while rsp_valid & !rsp_ready:
//   - req_ready=0 and no macro EN is asserted.
//   - rsp_valid and rsp_rdata hold.
//  Pop and new read in the same cycle (rsp_ready=1 with a read accepted): rsp_valid stays 1 and carries the new data.
//   Sustained read throughput is 1 per cycle.
//  Pop with no new read: rsp_valid falls next cycle. rsp_rdata keeps its last value.
//  Read-after-write to the same address in consecutive accepts returns the new data. The macro write completes first;
//   no bypass is needed.
//  Partial write: bytes whose mask bit is 0 are unchanged.
//  Out-of-range address: cannot occur (DEPTH is a power-of-2 multiple of 1024). Parameter checks:
//   - DATA_W%32 != 0 -> elaboration error.
//   - DEPTH%1024 != 0 -> elaboration error.
//   - DEPTH not a power of 2 -> elaboration error.
//  RESETn asserted mid-operation:
//   - Outputs return to reset values immediately; any in-flight response is dropped.
//   - Clear restarts from address 0 after release.
//  Macros are not reset. Contents are only guaranteed after CLEAR.
// STRUCTURE
//  Shared package ram_pkg: MACRO_W=32, MACRO_DEPTH=1024, MACRO_AW=10, FSM state encoding {ST_CLEAR, ST_RUN}.
//  Sub-module ram_macro_row: one row of COLS macros with a shared EN/A and a split WE/Di/Do.
//   - Selected by USE_BEH.
//   - Carries USE_POWER_PINS passthrough of VPWR/VGND.
//  Top level holds:
//   - the clear FSM and counter;
//   - the handshake logic and the row-select register;
//   - the output mux and the rsp hold register.
// TESTING
//  1. Reset, then release with CLEAR_EN=1 -> init_done rises exactly 1024 cycles later.
//     req_ready=0 until then. A read of 0x7FF then returns 0.
//  2. Write 0x0123456789ABCDEF to 0x400 (we=FF), then read 0x400 next cycle
//     -> rsp_valid one cycle after the read accept, rsp_rdata=0x0123456789ABCDEF.
//  3. Write FFFF_FFFF_FFFF_FFFF to 5, then write 0 to 5 with we=0x0F, then read 5 -> FFFF_FFFF_0000_0000.
//  4. Back-to-back reads of 0,1,2,3 with rsp_ready=1 -> four consecutive rsp_valid cycles, data in order.
//     Repeat with rsp_ready=0 for 3 cycles after the first response -> req_ready=0 and rsp_rdata stable for 3 cycles.
//  5. Read 0x3FF (row 0) then 0x400 (row 1) holding distinct values -> row select tracks, no cross-row data.
//  6. Assert RESETn low at clear count 500 and release -> clear restarts; init_done 1024 cycles after release.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the tiled DFFRAM controller.
// Macro geometry is fixed by the DFFRAM cell: 32 bits x 1024 words, byte write enables.
package ram_pkg;

  localparam int MACRO_W     = 32;
  localparam int MACRO_DEPTH = 1024;
  localparam int MACRO_AW    = 10;
  localparam int MACRO_BE    = MACRO_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/ram_banked_ctrl_if.sv
// Request/response bus between a core bus adapter (master) and ram_banked_ctrl (slave).
// Requests use valid/ready; read responses use valid/ready with the slave holding data under stall.
interface ram_banked_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int AW     = 11
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W/8-1:0] req_we;
  logic [AW-1:0]     req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/DFFRAM_4K.sv
// Simulation stand-in for the hardened 32x1024 DFFRAM macro; same pinout as DFFRAM_beh.
// The physical flow replaces this module with the hard macro view.
module DFFRAM_4K (
`ifdef USE_POWER_PINS
  inout  wire         VPWR,
  inout  wire         VGND,
`endif
  input  logic        CLK,
  input  logic [3:0]  WE,
  input  logic        EN,
  input  logic [31:0] Di,
  output logic [31:0] Do,
  input  logic [9:0]  A
);
  DFFRAM_beh u_core (
`ifdef USE_POWER_PINS
    .VPWR (VPWR),
    .VGND (VGND),
`endif
    .CLK  (CLK),
    .WE   (WE),
    .EN   (EN),
    .Di   (Di),
    .Do   (Do),
    .A    (A)
  );
endmodule

// File: rtl/DFFRAM_beh.sv
// Behavioural 32x1024 DFFRAM: byte-masked synchronous write, Do registered on every enabled edge.
// Do is only updated while EN is high, so it holds between accesses.
module DFFRAM_beh (
`ifdef USE_POWER_PINS
  inout  wire         VPWR,
  inout  wire         VGND,
`endif
  input  logic        CLK,
  input  logic [3:0]  WE,
  input  logic        EN,
  input  logic [31:0] Di,
  output logic [31:0] Do,
  input  logic [9:0]  A
);
  logic [31:0] mem [1024];

  always_ff @(posedge CLK) begin
    if (EN) begin
      for (int b = 0; b < 4; b++) begin
        if (WE[b]) mem[A][8*b +: 8] <= Di[8*b +: 8];
      end
      Do <= mem[A];
    end
  end
endmodule

// File: rtl/ram_macro_row.sv
// One row of COLS DFFRAM macros: shared EN/A, per-column 4-bit WE and 32-bit Di/Do slices.
// USE_BEH picks the behavioural model or the hard macro.
module ram_macro_row
  import ram_pkg::*;
#(
  parameter int COLS    = 2,
  parameter bit USE_BEH = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire                        VPWR,
  inout  wire                        VGND,
`endif
  input  logic                       CLK,
  input  logic                       EN,
  input  logic [COLS*MACRO_BE-1:0]   WE,
  input  logic [MACRO_AW-1:0]        A,
  input  logic [COLS*MACRO_W-1:0]    Di,
  output logic [COLS*MACRO_W-1:0]    Do
);
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (USE_BEH) begin : g_beh
      DFFRAM_beh u_mac (
`ifdef USE_POWER_PINS
        .VPWR (VPWR),
        .VGND (VGND),
`endif
        .CLK  (CLK),
        .WE   (WE[c*MACRO_BE +: MACRO_BE]),
        .EN   (EN),
        .Di   (Di[c*MACRO_W +: MACRO_W]),
        .Do   (Do[c*MACRO_W +: MACRO_W]),
        .A    (A)
      );
    end else begin : g_hard
      DFFRAM_4K u_mac (
`ifdef USE_POWER_PINS
        .VPWR (VPWR),
        .VGND (VGND),
`endif
        .CLK  (CLK),
        .WE   (WE[c*MACRO_BE +: MACRO_BE]),
        .EN   (EN),
        .Di   (Di[c*MACRO_W +: MACRO_W]),
        .Do   (Do[c*MACRO_W +: MACRO_W]),
        .A    (A)
      );
    end
  end
endmodule

// File: rtl/ram_banked_ctrl.sv
// DATA_W x DEPTH memory tiled from 32x1024 DFFRAMs; reset-time clear, read latency 1.
// Requests stall while a response is held unconsumed; response data is captured so it is immune to later macro traffic.
module ram_banked_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 2048,
  parameter bit CLEAR_EN = 1'b1,
  parameter bit USE_BEH  = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire  VPWR,
  inout  wire  VGND,
`endif
  input  logic CLK,
  input  logic RESETn,
  ram_banked_ctrl_if.slave bus
);
  localparam int COLS  = DATA_W / MACRO_W;
  localparam int ROWS  = DEPTH / MACRO_DEPTH;
  localparam int BE_W  = DATA_W / 8;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (DATA_W % MACRO_W != 0) begin : g_bad_width
    $error("ram_banked_ctrl: DATA_W must be a multiple of 32");
  end
  if (DEPTH % MACRO_DEPTH != 0) begin : g_bad_depth
    $error("ram_banked_ctrl: DEPTH must be a multiple of 1024");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_pow2
    $error("ram_banked_ctrl: DEPTH must be a power of 2");
  end

  state_t              state_q, state_d;
  logic [MACRO_AW-1:0] clr_addr_q, clr_addr_d;
  logic                init_done_q;

  logic                rsp_valid_q, rsp_valid_d;
  logic                fresh_q, fresh_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   hold_q, hold_d;

  logic [ROWS-1:0]     mac_en;
  logic [BE_W-1:0]     mac_we;
  logic [MACRO_AW-1:0] mac_a;
  logic [DATA_W-1:0]   mac_di;
  logic [DATA_W-1:0]   row_do [ROWS];
  logic [DATA_W-1:0]   do_sel;

  logic                req_ready;
  logic                accept_rd;
  logic [ROW_W-1:0]    req_row;

  assign req_row   = ROW_W'(bus.req_addr >> MACRO_AW);
  assign accept_rd = bus.req_valid & req_ready & (bus.req_we == '0);
  assign do_sel    = row_do[row_q];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= CLEAR_EN ? ST_CLEAR : ST_RUN;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Clear drives every row at once; in RUN only the addressed row is enabled.
  always_comb begin
    mac_en    = '0;
    mac_we    = bus.req_we;
    mac_a     = bus.req_addr[MACRO_AW-1:0];
    mac_di    = bus.req_wdata;
    req_ready = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        mac_en = '1;
        mac_we = '1;
        mac_a  = clr_addr_q;
        mac_di = '0;
      end
      ST_RUN: begin
        req_ready = init_done_q & (~rsp_valid_q | bus.rsp_ready);
        if (bus.req_valid & req_ready) mac_en[req_row] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (accept_rd)          rsp_valid_d = 1'b1;
    else if (bus.rsp_ready) rsp_valid_d = 1'b0;
    fresh_d = accept_rd;
    row_d   = accept_rd ? req_row : row_q;
    hold_d  = fresh_q ? do_sel : hold_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rsp_valid_q <= 1'b0;
      fresh_q     <= 1'b0;
      row_q       <= '0;
      hold_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      fresh_q     <= fresh_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
    end
  end

  // Fresh data comes straight from the macro in its first cycle, then from the hold register.
  assign bus.rsp_rdata = fresh_q ? do_sel : hold_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.req_ready = req_ready;
  assign bus.init_done = init_done_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    ram_macro_row #(
      .COLS    (COLS),
      .USE_BEH (USE_BEH)
    ) u_row (
`ifdef USE_POWER_PINS
      .VPWR (VPWR),
      .VGND (VGND),
`endif
      .CLK  (CLK),
      .EN   (mac_en[r]),
      .WE   (mac_we),
      .A    (mac_a),
      .Di   (mac_di),
      .Do   (row_do[r])
    );
  end
endmodule
